// File: rtl/mrelbp_ci_scheduler.sv
// Frame sequencer and result aligner for the MRELBP CI stage: buffers each radius
// lane's CI bits in its own FIFO and emits one aligned NR-bit vector per pixel.
module mrelbp_ci_scheduler #(
    parameter int COLS  = 7,
    parameter int ROWS  = 7,
    parameter int NR    = 4,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    input  logic [NR-1:0] ci_i,
    input  logic [NR-1:0] valid_i,
    input  logic [NR-1:0] progress_done_i,
    output logic [NR-1:0] ci_o,
    output logic          valid_o,
    output logic          frame_done_o,
    output logic          busy_o,
    output logic          overflow_o
);

    localparam int TOTAL = COLS * ROWS;
    localparam int CNT_W = $clog2(TOTAL + 1);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, WAIT_PD, DONE} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   pix_cnt_q;
    logic [NR-1:0]      pd_flag_q;
    logic [NR-1:0]      ci_q;
    logic               valid_q, frame_done_q, busy_q, overflow_q;

    logic [DEPTH-1:0]   mem_q    [NR];
    logic [PTR_W-1:0]   wr_ptr_q [NR];
    logic [PTR_W-1:0]   rd_ptr_q [NR];
    logic [OCC_W-1:0]   occ_q    [NR];

    logic               all_nonempty, pop, all_pd;
    logic [NR-1:0]      push, drop, pop_bits;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        all_nonempty = 1'b1;
        push         = '0;
        drop         = '0;
        pop_bits     = '0;
        for (int k = 0; k < NR; k++) begin
            if (occ_q[k] == '0) all_nonempty = 1'b0;
        end
        pop = (state_q == RUN) && all_nonempty && (pix_cnt_q < CNT_W'(TOTAL));
        // A full lane still accepts a push when it is popped on the same edge.
        for (int k = 0; k < NR; k++) begin
            pop_bits[k] = mem_q[k][rd_ptr_q[k]];
            if (state_q == RUN && valid_i[k]) begin
                if (occ_q[k] != OCC_W'(DEPTH) || pop) push[k] = 1'b1;
                else                                  drop[k] = 1'b1;
            end
        end
        all_pd  = &(pd_flag_q | progress_done_i);
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (pop && pix_cnt_q == CNT_W'(TOTAL - 1)) state_d = WAIT_PD;
            WAIT_PD: if (all_pd) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            pix_cnt_q    <= '0;
            pd_flag_q    <= '0;
            ci_q         <= '0;
            valid_q      <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            overflow_q   <= 1'b0;
            for (int k = 0; k < NR; k++) begin
                wr_ptr_q[k] <= '0;
                rd_ptr_q[k] <= '0;
                occ_q[k]    <= '0;
            end
        end else begin
            state_q      <= state_d;
            valid_q      <= pop;
            frame_done_q <= (state_q == WAIT_PD) && all_pd;
            busy_q       <= (state_d != IDLE);
            if (pop) ci_q <= pop_bits;
            if (state_q == IDLE && start_i) begin
                pix_cnt_q  <= '0;
                pd_flag_q  <= '0;
                overflow_q <= 1'b0;
                for (int k = 0; k < NR; k++) begin
                    wr_ptr_q[k] <= '0;
                    rd_ptr_q[k] <= '0;
                    occ_q[k]    <= '0;
                end
            end else begin
                if (pop) pix_cnt_q <= pix_cnt_q + CNT_W'(1);
                if (state_q == RUN || state_q == WAIT_PD) pd_flag_q <= pd_flag_q | progress_done_i;
                if (|drop) overflow_q <= 1'b1;
                for (int k = 0; k < NR; k++) begin
                    if (push[k]) wr_ptr_q[k] <= wr_ptr_q[k] + PTR_W'(1);
                    if (pop)     rd_ptr_q[k] <= rd_ptr_q[k] + PTR_W'(1);
                    occ_q[k] <= occ_q[k] + OCC_W'(push[k]) - OCC_W'(pop);
                end
            end
        end
    end

    // NOTE: FIFO storage is not reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NR; k++) begin
            if (push[k]) mem_q[k][wr_ptr_q[k]] <= ci_i[k];
        end
    end

    assign ci_o         = ci_q;
    assign valid_o      = valid_q;
    assign frame_done_o = frame_done_q;
    assign busy_o       = busy_q;
    assign overflow_o   = overflow_q;

endmodule

// File: tb/tb_mrelbp_ci_scheduler.sv
// Directed self-checking bench for mrelbp_ci_scheduler (NR=4, 7x7 frame, DEPTH=8).
module tb_mrelbp_ci_scheduler;

    localparam int NR = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic [NR-1:0] ci_i, valid_i, progress_done_i;
    logic [NR-1:0] ci_o;
    logic          valid_o, frame_done_o, busy_o, overflow_o;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int s_cyc, first_v, last_v, fd_cnt, fd_cyc, nb;
    logic [NR-1:0] got_q [$];

    mrelbp_ci_scheduler #(.COLS(7), .ROWS(7), .NR(NR), .DEPTH(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start_i),
        .ci_i           (ci_i),
        .valid_i        (valid_i),
        .progress_done_i(progress_done_i),
        .ci_o           (ci_o),
        .valid_o        (valid_o),
        .frame_done_o   (frame_done_o),
        .busy_o         (busy_o),
        .overflow_o     (overflow_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic pat(int n, int k);
        return ((n * 5 + k * 3 + (n >> 2)) % 7) < 3;
    endfunction

    function automatic logic [NR-1:0] exp_vec(int n);
        logic [NR-1:0] v;
        for (int k = 0; k < NR; k++) v[k] = pat(n, k);
        return v;
    endfunction

    function automatic int data_errs(int n);
        int e = 0;
        for (int i = 0; i < n; i++)
            if (i >= got_q.size() || got_q[i] !== exp_vec(i)) e++;
        return e;
    endfunction

    // Advance one cycle and record what the DUT shows in the new cycle.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        if (valid_o === 1'b1) begin
            got_q.push_back(ci_o);
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
        end
        if (frame_done_o === 1'b1) begin
            fd_cnt++;
            fd_cyc = cyc;
        end
    endtask

    task automatic clear_rec();
        got_q.delete();
        first_v = -1;
        last_v  = -1;
        fd_cnt  = 0;
        fd_cyc  = -1;
    endtask

    task automatic idle_inputs();
        valid_i         = '0;
        ci_i            = '0;
        progress_done_i = '0;
        start_i         = 1'b0;
    endtask

    task automatic start_frame();
        start_i = 1'b1;
        s_cyc   = cyc;
        step();
        start_i = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        idle_inputs();
        clear_rec();
        do_reset();
        check("rst_ci", ci_o, 0);
        check("rst_valid", valid_o, 0);
        check("rst_frame_done", frame_done_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_overflow", overflow_o, 0);

        // Aligned streams, progress done with the last pixel.
        clear_rec();
        start_frame();
        check("t1_busy_rise", busy_o, 1);
        for (int i = 0; i < 49; i++) begin
            valid_i         = '1;
            ci_i            = exp_vec(i);
            progress_done_i = (i == 48) ? '1 : '0;
            step();
        end
        idle_inputs();
        for (int j = 0; j < 10; j++) step();
        check("t1_count", got_q.size(), 49);
        check("t1_first_valid", first_v, s_cyc + 3);
        check("t1_last_valid", last_v, s_cyc + 51);
        check("t1_data", data_errs(49), 0);
        check("t1_fd_count", fd_cnt, 1);
        check("t1_fd_cycle", fd_cyc, s_cyc + 52);
        check("t1_busy_after", busy_o, 0);
        check("t1_overflow", overflow_o, 0);

        // Skewed lanes: lane 0 leads lane 3 by 5 cycles.
        clear_rec();
        start_frame();
        for (int i = 0; i < 54; i++) begin
            for (int k = 0; k < NR; k++) begin
                int off;
                int n;
                off        = (k == 0) ? 0 : (k == 1) ? 2 : (k == 2) ? 3 : 5;
                n          = i - off;
                valid_i[k] = (n >= 0 && n < 49);
                ci_i[k]    = (n >= 0 && n < 49) ? pat(n, k) : 1'b0;
            end
            progress_done_i = (i == 53) ? '1 : '0;
            step();
        end
        idle_inputs();
        for (int j = 0; j < 10; j++) step();
        check("t2_count", got_q.size(), 49);
        check("t2_first_valid", first_v, s_cyc + 8);
        check("t2_data", data_errs(49), 0);
        check("t2_overflow", overflow_o, 0);
        check("t2_fd_cycle", fd_cyc, s_cyc + 57);

        // Overflow: lane 3 silent while lanes 0-2 send 10 bits.
        clear_rec();
        start_frame();
        for (int i = 0; i < 10; i++) begin
            valid_i = 4'b0111;
            ci_i    = exp_vec(i);
            step();
            if (i == 7) check("t3_ovf_before_9th", overflow_o, 0);
            if (i == 8) check("t3_ovf_at_9th", overflow_o, 1);
        end
        check("t3_no_valid", got_q.size(), 0);
        for (int i = 0; i < 8; i++) begin
            valid_i = 4'b1000;
            ci_i    = exp_vec(i);
            step();
        end
        idle_inputs();
        for (int j = 0; j < 4; j++) step();
        check("t3_count", got_q.size(), 8);
        check("t3_data", data_errs(8), 0);
        check("t3_ovf_sticky", overflow_o, 1);
        do_reset();

        // Lane 0 full, push accepted because all lanes pop on the same edge.
        clear_rec();
        start_frame();
        for (int i = 0; i < 8; i++) begin
            valid_i = 4'b0001;
            ci_i    = exp_vec(i);
            step();
        end
        for (int n = 0; n < 9; n++) begin
            valid_i = (n == 1) ? 4'b1111 : 4'b1110;
            ci_i    = exp_vec(n);
            if (n == 1) ci_i[0] = pat(8, 0);
            step();
        end
        idle_inputs();
        for (int j = 0; j < 4; j++) step();
        check("t4_overflow", overflow_o, 0);
        check("t4_count", got_q.size(), 9);
        check("t4_data", data_errs(9), 0);
        do_reset();

        // Progress gating: lane 2 progress pulse 20 cycles after the others.
        clear_rec();
        start_frame();
        for (int i = 0; i < 49; i++) begin
            valid_i         = '1;
            ci_i            = exp_vec(i);
            progress_done_i = (i == 48) ? 4'b1011 : 4'b0000;
            step();
        end
        idle_inputs();
        nb = 0;
        while (cyc < s_cyc + 69) begin
            step();
            if (busy_o !== 1'b1) nb++;
        end
        check("t5_count", got_q.size(), 49);
        check("t5_data", data_errs(49), 0);
        check("t5_busy_wait", nb, 0);
        check("t5_no_early_fd", fd_cnt, 0);
        progress_done_i = 4'b0100;
        step();
        progress_done_i = '0;
        check("t5_fd_after_pulse", frame_done_o, 1);
        check("t5_fd_cycle", fd_cyc, s_cyc + 70);
        step();
        check("t5_fd_single", frame_done_o, 0);
        check("t5_busy_fall", busy_o, 0);

        // Stray valid_i in IDLE, second start in RUN, reset after 20 pixels.
        clear_rec();
        for (int j = 0; j < 3; j++) begin
            valid_i = '1;
            ci_i    = '1;
            step();
        end
        idle_inputs();
        check("t6_idle_no_valid", got_q.size(), 0);
        check("t6_idle_busy", busy_o, 0);
        start_frame();
        for (int i = 0; i < 40 && got_q.size() < 20; i++) begin
            valid_i = '1;
            ci_i    = exp_vec(i);
            start_i = (i == 5);
            step();
        end
        start_i = 1'b0;
        check("t6_count", got_q.size(), 20);
        check("t6_data", data_errs(20), 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        idle_inputs();
        check("t6_rst_ci", ci_o, 0);
        check("t6_rst_valid", valid_o, 0);
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_overflow", overflow_o, 0);
        check("t6_rst_frame_done", frame_done_o, 0);
        for (int j = 0; j < 5; j++) step();
        check("t6_no_fd", fd_cnt, 0);
        check("t6_quiet_after_rst", got_q.size(), 20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mrelbp_ci_scheduler.md
# mrelbp_ci_scheduler

Frame-level sequencer and result aligner for the MRELBP CI stage. It sits behind NR parallel per-radius CI units (R2, R4, …), each of which produces one CI bit per pixel with its own pipeline latency. The block opens and closes a frame, buffers each lane's CI bits in a per-lane FIFO, and emits one aligned NR-bit CI vector per pixel. It closes the frame only when COLS*ROWS vectors have been emitted and every lane has reported progress completion.

## Interface
- COLS, 7, frame width in pixels
- ROWS, 7, frame height in pixels
- NR, 4, number of radius lanes
- DEPTH, 8, per-lane FIFO depth (power of 2, ≥ 2)
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- start_i  input  1  frame start pulse; honoured only in IDLE
- ci_i  input  NR  CI bit per lane
- valid_i  input  NR  per-lane strobe qualifying ci_i[k] (the unit's done_o)
- progress_done_i  input  NR  per-lane progress-done pulse
- ci_o  output  NR  aligned CI vector; bit k from lane k
- valid_o  output  1  ci_o valid, one cycle per pixel
- frame_done_o  output  1  one-cycle pulse at frame close
- busy_o  output  1  high whenever state ≠ IDLE
- overflow_o  output  1  sticky flag: a push was dropped on a full FIFO

## Operation
- States: IDLE, RUN, WAIT_PD, DONE.
- IDLE → RUN on start_i. On this transition:
  - flush all FIFOs;
  - clear the pixel counter, the progress flags and overflow_o.
- RUN:
  - Push ci_i[k] into FIFO k when valid_i[k] is high.
  - Pop all lanes together when every FIFO is non-empty and the pixel counter < COLS*ROWS.
  - Each pop increments the pixel counter.
- RUN → WAIT_PD on the edge that performs the COLS*ROWS-th pop.
- WAIT_PD → DONE when all NR progress flags are set. A progress_done_i that arrives in the same cycle counts.
- DONE → IDLE unconditionally after one cycle.
- Progress flags: pd_flag[k] is set by progress_done_i[k] in RUN or WAIT_PD, and is sticky until the next frame start.
- Push on a full lane:
  - accepted if that lane pops in the same cycle;
  - otherwise the bit is dropped and overflow_o is set.
- Pushes outside RUN are ignored. They do not set overflow_o.
- start_i outside IDLE is ignored.
- Pixel counter width is clog2(COLS*ROWS+1). It saturates at COLS*ROWS.
- FIFO occupancy width is clog2(DEPTH+1). Read and write pointers are clog2(DEPTH) bits and wrap modulo DEPTH.

## Timing
- Reset values:
  - ci_o = 0, valid_o = 0, frame_done_o = 0, busy_o = 0, overflow_o = 0;
  - state IDLE; FIFOs empty; counter 0; flags 0.
- rst asserted mid-frame forces the reset state on the next edge. No frame_done_o is issued.
- Latency (minimum 2 cycles):
  - valid_i[k] high in cycle t writes the FIFO at the end of cycle t.
  - If every lane is non-empty in cycle t+1, the pop decision is combinational in t+1.
  - ci_o and valid_o are registered and appear in cycle t+2.
- The latest-arriving lane sets the pop cycle.
- Throughput: one vector per cycle when all lanes stream back-to-back.
- The last valid_o appears in the first WAIT_PD cycle.
- frame_done_o is high in the DONE cycle only, exactly 1 cycle, and no earlier than 1 cycle after the last valid_o.
- busy_o rises in the cycle after start_i is sampled. It falls in the cycle after DONE.
- valid_o is 0 in all cycles without a preceding pop. ci_o holds its last value when valid_o = 0.

## Test plan
- **Aligned streams:** NR=4, 7×7. All lanes pulse valid_i every cycle from the cycle after start; progress_done_i all pulse at pixel 49. Required: 49 valid_o cycles, first at start+3; ci_o equals the ci_i pattern; single frame_done_o; busy_o low afterwards.
- **Skewed lanes:** lane 0 leads lane 3 by 5 cycles, DEPTH=8. Required: no overflow; each ci_o vector pairs the n-th bit of every lane; first valid_o 2 cycles after lane 3's first valid_i.
- **Overflow:** lane 3 silent, lanes 0–2 stream 10 bits, DEPTH=8. Required: overflow_o set at the 9th push; no valid_o. After lane 3 sends 8 bits, 8 vectors come out carrying lane bits 0–7.
- **Full plus simultaneous pop:** lane 0 full while all lanes are non-empty and a push arrives. Required: the push is accepted and overflow_o stays 0.
- **Progress gating:** all 49 pixels emitted; lane 2 progress_done_i arrives 20 cycles late. Required: the block stays in WAIT_PD with busy_o high; frame_done_o fires the cycle after that pulse.
- **Reset and stray inputs:**
  - rst after 20 pixels: all outputs reach their reset values the next cycle.
  - A second start_i during RUN is ignored.
  - valid_i while IDLE is ignored.
